// File: rtl/proc_cmd_sched.sv
// proc_cmd_sched: shares the bit-serial register/compute/router datapath between two requesters
//
// Purpose:
//   Arbitrates between requester 0 and requester 1. Sequences the datapath strobes
//   (Ld_A, Ld_B, Shift_En) and holds D/F_S/R_S stable for each command. Pulses a
//   per-requester done when a command completes.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                      undefined -> round-robin; requester 0 wins first after reset
//
// Ports:
//   Clk, Reset_n               clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    command handshake (ready is combinational, only in IDLE)
//   reqN_op                    00 LOADA, 01 LOADB, 10 EXEC, 11 NOP
//   reqN_data                  load value for LOADA/LOADB
//   reqN_f / reqN_r            function / routing select for EXEC
//   reqN_done                  one-cycle completion pulse to the owning requester
//   Ld_A, Ld_B, Shift_En       registered datapath strobes (mutually exclusive)
//   D, F_S, R_S                registered datapath data/selects, held between commands
//   busy                       high whenever the scheduler is not IDLE
//   owner                      requester owning the current or last command
module proc_cmd_sched #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [2:0]       req0_f,
  input  logic [1:0]       req0_r,
  output logic             req0_done,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [2:0]       req1_f,
  input  logic [1:0]       req1_r,
  output logic             req1_done,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic [WIDTH-1:0] D,
  output logic [2:0]       F_S,
  output logic [1:0]       R_S,
  output logic             busy,
  output logic             owner
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_LOADA = 2'b00;
  localparam logic [1:0] OP_LOADB = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_last;
  logic [1:0]       r_done, w_done_n;
  logic             w_lda_n, w_ldb_n, w_sh_n;
  logic [WIDTH-1:0] w_d_n;
  logic [2:0]       w_f_n;
  logic [1:0]       w_r_n;
  logic             w_idle, w_grant, w_acc;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [2:0]       w_f;
  logic [1:0]       w_r;
  assign w_idle = (r_state == IDLE);
  // w_grant is the index of the winning requester; it only matters when that requester is valid.
`ifdef ARB_FIXED_PRIO_EN
  assign w_grant = !req0_valid;
`else
  assign w_grant = (req0_valid && req1_valid) ? !r_last : req1_valid;
`endif
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_acc      = req0_ready || req1_ready;
  assign w_op       = w_grant ? req1_op   : req0_op;
  assign w_data     = w_grant ? req1_data : req0_data;
  assign w_f        = w_grant ? req1_f    : req0_f;
  assign w_r        = w_grant ? req1_r    : req0_r;
  assign req0_done  = r_done[0];
  assign req1_done  = r_done[1];
  // Strobes are computed one cycle ahead so that every datapath output comes straight from a flop.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_lda_n   = 1'b0;
    w_ldb_n   = 1'b0;
    w_sh_n    = 1'b0;
    w_done_n  = 2'b00;
    w_d_n     = D;
    w_f_n     = F_S;
    w_r_n     = R_S;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_op == OP_LOADA || w_op == OP_LOADB) begin
            w_state_n = LOAD;
            w_lda_n   = (w_op == OP_LOADA);
            w_ldb_n   = (w_op == OP_LOADB);
            w_d_n     = w_data;
          end else if (w_op == OP_EXEC) begin
            w_state_n = SHIFT;
            w_cnt_n   = CNT_W'(WIDTH);
            w_sh_n    = 1'b1;
            w_f_n     = w_f;
            w_r_n     = w_r;
          end else begin
            w_state_n = DONE;
            w_done_n  = w_grant ? 2'b10 : 2'b01;
          end
        end
      end
      LOAD: begin
        w_state_n = DONE;
        w_done_n  = owner ? 2'b10 : 2'b01;
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_n = DONE;
          w_done_n  = owner ? 2'b10 : 2'b01;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
          w_sh_n  = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_done   <= 2'b00;
      Ld_A     <= 1'b0;
      Ld_B     <= 1'b0;
      Shift_En <= 1'b0;
      D        <= '0;
      F_S      <= '0;
      R_S      <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_done   <= w_done_n;
      Ld_A     <= w_lda_n;
      Ld_B     <= w_ldb_n;
      Shift_En <= w_sh_n;
      D        <= w_d_n;
      F_S      <= w_f_n;
      R_S      <= w_r_n;
      busy     <= (w_state_n != IDLE);
      if (w_acc) begin
        r_last <= w_grant;
        owner  <= w_grant;
      end
    end
  end
endmodule

// File: tb/tb_proc_cmd_sched.sv
// tb_proc_cmd_sched: directed table, corner-case sequences and a randomized transaction-level model check
module tb_proc_cmd_sched;
  localparam int W  = 8;
  localparam int NR = 1500;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic req0_valid, req0_ready, req0_done, req1_valid, req1_ready, req1_done;
  logic [1:0] req0_op, req1_op, req0_r, req1_r, R_S;
  logic [W-1:0] req0_data, req1_data, D;
  logic [2:0] req0_f, req1_f, F_S;
  logic Ld_A, Ld_B, Shift_En, busy, owner;
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;
  proc_cmd_sched #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req0_f(req0_f), .req0_r(req0_r), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .req1_f(req1_f), .req1_r(req1_r), .req1_done(req1_done),
    .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .D(D), .F_S(F_S), .R_S(R_S),
    .busy(busy), .owner(owner)
  );
  typedef struct {
    bit         idx;
    logic [1:0] op;
    logic [7:0] data;
    logic [2:0] f;
    logic [1:0] r;
    int         lat, n_lda, n_ldb, n_sh;
    logic [7:0] e_d;
    logic [2:0] e_f;
    logic [1:0] e_r;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input bit idx, input bit v, input logic [1:0] op, input logic [W-1:0] d,
                       input logic [2:0] f, input logic [1:0] r);
    if (!idx) begin
      req0_valid = v; req0_op = op; req0_data = d; req0_f = f; req0_r = r;
    end else begin
      req1_valid = v; req1_op = op; req1_data = d; req1_f = f; req1_r = r;
    end
  endtask
  task automatic do_reset();
    drive(0, 0, 2'b11, '0, '0, '0);
    drive(1, 0, 2'b11, '0, '0, '0);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask
  task automatic run_vec(input vec_t v);
    int lat = -1, nd = 0, nwrong = 0, na = 0, nb = 0, ns = 0, nbad = 0;
    logic [7:0] sd = '0;
    logic [2:0] sf = '0;
    logic [1:0] sr = '0;
    logic so = 1'b0;
    drive(v.idx, 1, v.op, v.data, v.f, v.r);
    @(negedge Clk);
    chk("vec_ready", v.idx ? req1_ready : req0_ready, 1);
    @(posedge Clk);
    #1 drive(v.idx, 0, 2'b11, '0, '0, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      na += int'(Ld_A); nb += int'(Ld_B); ns += int'(Shift_En);
      if (Shift_En && (F_S !== v.e_f || R_S !== v.e_r)) nbad++;
      if ((Ld_A || Ld_B) && D !== v.data) nbad++;
      if (k == 1) chk("vec_busy", busy, 1);
      if (v.idx ? req1_done : req0_done) begin
        nd++;
        if (lat < 0) begin lat = k; sd = D; sf = F_S; sr = R_S; so = owner; end
      end
      if (v.idx ? req0_done : req1_done) nwrong++;
    end
    @(posedge Clk);
    #1;
    chk("vec_latency", lat, v.lat);
    chk("vec_done_count", nd, 1);
    chk("vec_other_done", nwrong, 0);
    chk("vec_lda_cycles", na, v.n_lda);
    chk("vec_ldb_cycles", nb, v.n_ldb);
    chk("vec_shift_cycles", ns, v.n_sh);
    chk("vec_hold_errors", nbad, 0);
    chk("vec_D", sd, v.e_d);
    chk("vec_F_S", sf, v.e_f);
    chk("vec_R_S", sr, v.e_r);
    chk("vec_owner", so, v.idx);
  endtask
  bit e_lda[NR+W+4], e_ldb[NR+W+4], e_sh[NR+W+4], e_dn0[NR+W+4], e_dn1[NR+W+4];
  initial begin
    int waited, nd;
    bit got;
    bit rv[2];
    logic [1:0] rop[2];
    logic [W-1:0] rdat[2];
    logic [2:0] rf[2];
    logic [1:0] rr[2];
    bit m_last, m_owner, acc, g;
    logic [W-1:0] m_d;
    logic [2:0] m_f;
    logic [1:0] m_r;
    int free_at, lat;
    tbl[0] = '{1'b0, 2'b00, 8'h3C, 3'd0, 2'd0, 2, 1, 0, 0, 8'h3C, 3'd0, 2'd0};
    tbl[1] = '{1'b1, 2'b10, 8'h00, 3'b010, 2'b01, 9, 0, 0, 8, 8'h3C, 3'b010, 2'b01};
    tbl[2] = '{1'b1, 2'b01, 8'hA5, 3'd0, 2'd0, 2, 0, 1, 0, 8'hA5, 3'b010, 2'b01};
    tbl[3] = '{1'b0, 2'b11, 8'hFF, 3'd7, 2'd3, 1, 0, 0, 0, 8'hA5, 3'b010, 2'b01};
    tbl[4] = '{1'b0, 2'b10, 8'h00, 3'd7, 2'd3, 9, 0, 0, 8, 8'hA5, 3'd7, 2'd3};
    tbl[5] = '{1'b1, 2'b00, 8'h5A, 3'd0, 2'd0, 2, 1, 0, 0, 8'h5A, 3'd7, 2'd3};
    do_reset();
    @(negedge Clk);
    chk("rst_strobes", {Ld_A, Ld_B, Shift_En}, 0);
    chk("rst_D_F_R", {D, F_S, R_S}, 0);
    chk("rst_done", {req0_done, req1_done}, 0);
    chk("rst_busy_owner", {busy, owner}, 0);
    @(posedge Clk);
    #1;
    foreach (tbl[i]) run_vec(tbl[i]);
    // Contention after reset: both issue LOADB, requester 0 wins first.
    do_reset();
    drive(0, 1, 2'b01, 8'h11, '0, '0);
    drive(1, 1, 2'b01, 8'h22, '0, '0);
    @(negedge Clk);
    chk("cont_ready0", req0_ready, 1);
    chk("cont_ready1", req1_ready, 0);
    @(posedge Clk);
    #1 drive(0, 0, 2'b11, '0, '0, '0);
    @(negedge Clk);
    chk("cont_ldb0", {Ld_B, D, owner}, {1'b1, 8'h11, 1'b0});
    chk("cont_ready1_load", req1_ready, 0);
    @(negedge Clk);
    chk("cont_done0", {req0_done, req1_done}, 2'b10);
    chk("cont_ready1_done", req1_ready, 0);
    @(negedge Clk);
    chk("cont_ready1_idle", req1_ready, 1);
    @(posedge Clk);
    #1 drive(1, 0, 2'b11, '0, '0, '0);
    @(negedge Clk);
    chk("cont_ldb1", {Ld_B, D, owner}, {1'b1, 8'h22, 1'b1});
    @(negedge Clk);
    chk("cont_done1", {req0_done, req1_done}, 2'b01);
    @(posedge Clk);
    #1;
    // Reset asserted on the 4th shift cycle of an EXEC.
    drive(0, 1, 2'b10, '0, 3'd5, 2'd2);
    @(negedge Clk);
    chk("rmid_ready", req0_ready, 1);
    @(posedge Clk);
    #1 drive(0, 0, 2'b11, '0, '0, '0);
    repeat (4) @(negedge Clk);
    chk("rmid_shift4", Shift_En, 1);
    Reset_n = 1'b0;
    #1;
    chk("rmid_shift_drop", Shift_En, 0);
    chk("rmid_busy_drop", busy, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      nd += int'(req0_done) + int'(req1_done) + int'(Shift_En);
    end
    chk("rmid_no_done", nd, 0);
    chk("rmid_busy", busy, 0);
    @(posedge Clk);
    #1;
    drive(0, 1, 2'b11, '0, '0, '0);
    drive(1, 1, 2'b11, '0, '0, '0);
    @(negedge Clk);
    chk("rmid_cont", {req0_ready, req1_ready}, 2'b10);
    @(posedge Clk);
    #1;
    drive(0, 0, 2'b11, '0, '0, '0);
    drive(1, 0, 2'b11, '0, '0, '0);
    repeat (3) @(posedge Clk);
    #1;
    // Requester 1 asks for LOADA while requester 0's EXEC is shifting.
    drive(0, 1, 2'b10, '0, 3'd1, 2'd0);
    @(negedge Clk);
    chk("busy_ready0", req0_ready, 1);
    @(posedge Clk);
    #1 drive(0, 0, 2'b11, '0, '0, '0);
    drive(1, 1, 2'b00, 8'h77, '0, '0);
    waited = 0;
    got = 0;
    for (int k = 0; k < 15 && !got; k++) begin
      @(negedge Clk);
      if (req1_ready) got = 1;
      else waited++;
    end
    chk("busy_got_ready", got, 1);
    chk("busy_wait_cycles", waited, 9);
    @(posedge Clk);
    #1 drive(1, 0, 2'b11, '0, '0, '0);
    @(negedge Clk);
    chk("busy_lda", {Ld_A, D, owner}, {1'b1, 8'h77, 1'b1});
    repeat (2) @(posedge Clk);
    #1;
    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last = 1; m_owner = 0; m_d = '0; m_f = '0; m_r = '0; free_at = 0;
    rv[0] = 0; rv[1] = 0;
    for (int n = 0; n < NR; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rv[i] = 1; rop[i] = 2'($urandom); rdat[i] = W'($urandom);
            rf[i] = 3'($urandom); rr[i] = 2'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) rv[i] = 0;
        drive(i[0], rv[i], rop[i], rdat[i], rf[i], rr[i]);
      end
      acc = (n >= free_at) && (rv[0] || rv[1]);
`ifdef ARB_FIXED_PRIO_EN
      g = !rv[0];
`else
      g = (rv[0] && rv[1]) ? !m_last : rv[1];
`endif
      @(negedge Clk);
      chk("rnd_ready0", req0_ready, acc && !g);
      chk("rnd_ready1", req1_ready, acc && g);
      chk("rnd_Ld_A", Ld_A, e_lda[n]);
      chk("rnd_Ld_B", Ld_B, e_ldb[n]);
      chk("rnd_Shift_En", Shift_En, e_sh[n]);
      chk("rnd_done0", req0_done, e_dn0[n]);
      chk("rnd_done1", req1_done, e_dn1[n]);
      chk("rnd_busy", busy, n < free_at);
      chk("rnd_D", D, m_d);
      chk("rnd_F_S", F_S, m_f);
      chk("rnd_R_S", R_S, m_r);
      chk("rnd_owner", owner, m_owner);
      if (acc) begin
        m_owner = g; m_last = g; rv[g] = 0;
        case (rop[g])
          2'b00: begin e_lda[n+1] = 1; m_d = rdat[g]; lat = 2; end
          2'b01: begin e_ldb[n+1] = 1; m_d = rdat[g]; lat = 2; end
          2'b10: begin
            for (int k = 1; k <= W; k++) e_sh[n+k] = 1;
            m_f = rf[g]; m_r = rr[g]; lat = W + 1;
          end
          default: lat = 1;
        endcase
        if (g) e_dn1[n+lat] = 1;
        else e_dn0[n+lat] = 1;
        free_at = n + lat + 1;
      end
      @(posedge Clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_cmd_sched.md
Name: proc_cmd_sched

Overview:
- Command scheduler that shares the 8-bit bit-serial logic datapath (A/B shift registers, compute unit, router) between two requesters, e.g. the push-button front end and a host command port.
- Arbitrates between the requesters.
- Sequences the datapath strobes (Ld_A, Ld_B, Shift_En) and holds D/F/R stable for the duration of each command.
- Returns a per-requester done pulse when a command completes.

Parameters:
- WIDTH, 8: register width; number of Shift_En cycles per EXEC.
- CNT_W, $clog2(WIDTH+1): shift counter width. Derived; do not override.

Ports:
- Clk in 1: system clock.
- Reset_n in 1: asynchronous, active-low reset.
- req0_valid in 1: requester 0 command valid.
- req0_ready out 1: requester 0 command accepted this cycle when valid is also high.
- req0_op in 2: 00 LOADA, 01 LOADB, 10 EXEC, 11 NOP.
- req0_data in WIDTH: load value for LOADA/LOADB.
- req0_f in 3: function select for EXEC.
- req0_r in 2: routing select for EXEC.
- req0_done out 1: one-cycle completion pulse for requester 0.
- req1_valid, req1_ready, req1_op, req1_data, req1_f, req1_r, req1_done: same as requester 0, for requester 1.
- Ld_A out 1: load strobe to register unit.
- Ld_B out 1: load strobe to register unit.
- Shift_En out 1: shift enable to register unit.
- D out WIDTH: parallel load data to register unit.
- F_S out 3: function select to compute unit.
- R_S out 2: routing select to router.
- busy out 1: high in any state other than IDLE.
- owner out 1: index of the requester owning the current or last command.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. State, counter, command latches and all outputs except ready are registered.
- Reset (Reset_n low, asynchronous):
  - state = IDLE; Ld_A = Ld_B = Shift_En = 0.
  - D = 0, F_S = 0, R_S = 0; done = 0; busy = 0; owner = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- IDLE:
  - grant = round-robin: if both requesters are valid, grant the one != last_grant; if only one is valid, grant it.
  - reqN_ready = (state == IDLE) && grant == N. This is combinational from registered state and the valids.
  - The non-granted ready is 0.
- Accept at clock edge t (valid && ready):
  - Latch op, data, f, r; owner = N; last_grant = N.
  - Next state: LOADA/LOADB -> LOAD; EXEC -> SHIFT with counter = WIDTH; NOP -> DONE.
- LOAD (1 cycle, t+1):
  - D = latched data.
  - Ld_A = 1 for LOADA, or Ld_B = 1 for LOADB; exactly one strobe for one cycle.
  - Next state: DONE.
- SHIFT (cycles t+1 .. t+WIDTH):
  - Shift_En = 1 for exactly WIDTH consecutive cycles.
  - F_S and R_S hold the latched values; counter decrements each cycle.
  - Exit to DONE when the counter reaches 1.
- DONE (1 cycle):
  - reqN_done = 1 for owner only; all strobes 0.
  - Next state: IDLE. No command is accepted during DONE.
- Latency:
  - LOAD command: done at t+2.
  - EXEC command: done at t+WIDTH+1.
  - NOP command: done at t+1.
  - Next accept: earliest one cycle after the done cycle.
- D, F_S and R_S hold their last value until the next accept that changes them. LOAD updates D only; EXEC updates F_S/R_S only.
- Requesters hold valid and fields stable until accepted. A valid dropped before acceptance is ignored; no partial state results.
- A request arriving during LOAD/SHIFT/DONE waits in IDLE arbitration. Ready stays 0 while busy.
- Reset asserted mid-command: all strobes drop immediately; the in-flight command is discarded with no done pulse.
- Strobes are mutually exclusive; at most one of Ld_A, Ld_B, Shift_En is high in any cycle.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority; requester 0 always wins contention. last_grant is still tracked but not used for arbitration.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as specified in Behaviour.

Test Plan:
- LOADA, single requester: req0 LOADA data=8'h3C -> req0_ready=1 at t; Ld_A=1 with D=8'h3C only at t+1; req0_done at t+2; Ld_B and Shift_En stay 0.
- EXEC: req1 EXEC f=3'b010, r=2'b01 -> Shift_En high for exactly 8 consecutive cycles (t+1..t+8); F_S=3'b010 and R_S=2'b01 throughout; req1_done at t+9; busy high t+1..t+9.
- Contention after reset: both requesters issue LOADB in the same cycle -> req0 granted first, req1 granted in the IDLE after req0_done; owner sequence 0,1. With ARB_FIXED_PRIO_EN and req0 re-requesting continuously, req0 wins every time and req1 is starved.
- Back-to-back round-robin: both requesters continuously issue NOP -> grants alternate 0,1,0,1; each done pulse is one cycle; accept spacing is 2 cycles.
- Reset mid-EXEC: assert Reset_n=0 at the 4th Shift_En cycle -> Shift_En=0 immediately; no done pulse; after release, state is IDLE, busy=0, and the next contention is won by req0.
- Request during busy: req1 asserts LOADA while req0 EXEC is in SHIFT -> req1_ready stays 0 until IDLE, then req1 is accepted and Ld_A occurs on the following cycle.
